branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 131 +++++++++++++
 tb/tb_branch_resolve.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch compare/resolve unit with a single registered valid/ready output stage.
// Statistics counters are compiled in with `define BRANCH_RESOLVE_STATS_EN.
module branch_resolve #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [31:0]          in_inst,
  input  logic                 in_pred_taken,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_is_branch,
  output logic                 out_taken,
  output logic                 out_mispredict,
  output logic                 out_illegal,
  output logic                 out_eq,
  output logic                 out_lt,
  input  logic                 stat_clr,
  output logic [CNT_WIDTH-1:0] stat_branches,
  output logic [CNT_WIDTH-1:0] stat_mispredicts
);

  logic [2:0] f3;
  logic       is_br;
  logic       eq_raw;
  logic       lt_raw;
  logic       tk_raw;
  logic       ill_raw;
  logic       n_eq;
  logic       n_lt;
  logic       n_tk;
  logic       n_ill;
  logic       n_mis;
  logic       accept;
  logic       drain;

  assign f3     = in_inst[14:12];
  assign is_br  = (in_inst[6:0] == 7'b1100011);
  assign eq_raw = (in_a == in_b);

  always_comb begin
    lt_raw  = (in_a < in_b);
    tk_raw  = 1'b0;
    ill_raw = 1'b0;
    unique case (1'b1)
      (f3 == 3'b100) || (f3 == 3'b101):
        lt_raw = ($signed(in_a) < $signed(in_b));
      default: ;
    endcase
    unique case (1'b1)
      f3 == 3'b000: tk_raw = eq_raw;
      f3 == 3'b001: tk_raw = !eq_raw;
      f3 == 3'b100,
      f3 == 3'b110: tk_raw = lt_raw;
      f3 == 3'b101,
      f3 == 3'b111: tk_raw = !lt_raw;
      default:      ill_raw = 1'b1;
    endcase
  end

  // Non-branch instructions carry no compare or prediction information.
  assign n_eq  = is_br && eq_raw;
  assign n_lt  = is_br && lt_raw;
  assign n_tk  = is_br && tk_raw;
  assign n_ill = is_br && ill_raw;
  assign n_mis = is_br && !ill_raw && (tk_raw != in_pred_taken);

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_is_branch  <= 1'b0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      out_illegal    <= 1'b0;
      out_eq         <= 1'b0;
      out_lt         <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_is_branch  <= is_br;
      out_taken      <= n_tk;
      out_mispredict <= n_mis;
      out_illegal    <= n_ill;
      out_eq         <= n_eq;
      out_lt         <= n_lt;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [CNT_WIDTH-1:0] br_q;
  logic [CNT_WIDTH-1:0] mis_q;

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q  <= '0;
      mis_q <= '0;
    end else if (stat_clr) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      if (drain && out_is_branch && (br_q != '1))
        br_q <= br_q + 1'b1;
      if (drain && out_mispredict && (mis_q != '1))
        mis_q <= mis_q + 1'b1;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mis_q;
`else
  logic unused_clr;
  assign unused_clr       = stat_clr;
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed-vector bench for branch_resolve.
// Counter expectations follow BRANCH_RESOLVE_STATS_EN.
module tb_branch_resolve;

`ifdef BRANCH_RESOLVE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [31:0]   in_inst;
  logic          in_pred_taken;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          out_is_branch;
  logic          out_taken;
  logic          out_mispredict;
  logic          out_illegal;
  logic          out_eq;
  logic          out_lt;
  logic          stat_clr;
  logic [CW-1:0] stat_branches;
  logic [CW-1:0] stat_mispredicts;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .in_inst          (in_inst),
    .in_pred_taken    (in_pred_taken),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_is_branch    (out_is_branch),
    .out_taken        (out_taken),
    .out_mispredict   (out_mispredict),
    .out_illegal      (out_illegal),
    .out_eq           (out_eq),
    .out_lt           (out_lt),
    .stat_clr         (stat_clr),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3,
                                     input logic [6:0] op);
    return {17'd0, f3, 5'd0, op};
  endfunction

  // Present one request for one cycle; returns #1 after the accepting edge.
  task automatic drive(input logic [31:0] inst, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic pred);
    @(negedge clk);
    in_valid      = 1'b1;
    in_inst       = inst;
    in_a          = a;
    in_b          = b;
    in_pred_taken = pred;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_stats(input string tag, input int br, input int mis);
    check({tag, "_br"}, 64'(stat_branches), STATS ? 64'(br) : 64'd0);
    check({tag, "_mis"}, 64'(stat_mispredicts), STATS ? 64'(mis) : 64'd0);
  endtask

  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] ALU = 7'b0010011;

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_a          = '0;
    in_b          = '0;
    in_inst       = '0;
    in_pred_taken = 1'b0;
    flush         = 1'b0;
    out_ready     = 1'b1;
    stat_clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_taken", 64'(out_taken), 64'd0);
    chk_stats("rst", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", 64'(in_ready), 64'd1);

    // BLT: -1 < 1 signed
    drive(mk(3'b100, BR), 32'hFFFF_FFFF, 32'd1, 1'b0);
    check("blt_valid", 64'(out_valid), 64'd1);
    check("blt_taken", 64'(out_taken), 64'd1);
    check("blt_lt", 64'(out_lt), 64'd1);
    check("blt_mis", 64'(out_mispredict), 64'd1);
    check("blt_ill", 64'(out_illegal), 64'd0);
    @(posedge clk);
    #1;
    check("blt_drained", 64'(out_valid), 64'd0);
    chk_stats("blt", 1, 1);

    // BLTU: 0xFFFFFFFF > 1 unsigned
    drive(mk(3'b110, BR), 32'hFFFF_FFFF, 32'd1, 1'b1);
    check("bltu_taken", 64'(out_taken), 64'd0);
    check("bltu_lt", 64'(out_lt), 64'd0);
    check("bltu_mis", 64'(out_mispredict), 64'd1);
    @(posedge clk);
    #1;
    chk_stats("bltu", 2, 2);

    // BGE signed: -1 >= 1 is false
    drive(mk(3'b101, BR), 32'hFFFF_FFFF, 32'd1, 1'b0);
    check("bge_taken", 64'(out_taken), 64'd0);
    check("bge_lt", 64'(out_lt), 64'd1);
    check("bge_mis", 64'(out_mispredict), 64'd0);
    @(posedge clk);
    #1;
    chk_stats("bge", 3, 2);

    // BEQ held under backpressure while another request waits
    out_ready = 1'b0;
    drive(mk(3'b000, BR), 32'd5, 32'd5, 1'b1);
    check("beq_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    in_valid = 1'b1;
    in_inst  = mk(3'b001, BR);
    in_a     = 32'd1;
    in_b     = 32'd2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_taken", 64'(out_taken), 64'd1);
      check("hold_eq", 64'(out_eq), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    check("beq_drained", 64'(out_valid), 64'd0);
    chk_stats("beq", 4, 2);

    // Illegal funct3 branch then ADDI, back to back
    drive(mk(3'b010, BR), 32'd7, 32'd7, 1'b1);
    check("ill_flag", 64'(out_illegal), 64'd1);
    check("ill_taken", 64'(out_taken), 64'd0);
    check("ill_mis", 64'(out_mispredict), 64'd0);
    drive(mk(3'b000, ALU), 32'd7, 32'd7, 1'b1);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_isbr", 64'(out_is_branch), 64'd0);
    check("addi_mis", 64'(out_mispredict), 64'd0);
    check("addi_eq", 64'(out_eq), 64'd0);
    @(posedge clk);
    #1;
    chk_stats("ill", 5, 2);

    // Flush beats a same-cycle accept
    flush = 1'b1;
    drive(mk(3'b001, BR), 32'd1, 32'd2, 1'b0);
    flush = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk_stats("flush", 5, 2);

    // Saturation and clear
    @(negedge clk);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    chk_stats("clr0", 0, 0);
    for (int i = 0; i < 17; i++)
      drive(mk(3'b000, BR), 32'd9, 32'd9, 1'b0);
    @(posedge clk);
    #1;
    chk_stats("sat", 15, 15);
    @(negedge clk);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    chk_stats("clr1", 0, 0);

    // Reset while a result is held
    out_ready = 1'b0;
    drive(mk(3'b000, BR), 32'd3, 32'd3, 1'b0);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_taken", 64'(out_taken), 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_drop_valid", 64'(out_valid), 64'd0);
    check("rst_drop_ready", 64'(in_ready), 64'd1);
    chk_stats("rst_drop", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
